data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl_if.sv | 25 ++
 rtl/data_mem_ctrl.sv | 146 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between a load/store unit and the data memory controller.
// A request transfers on the rising edge where DMEM_req and DMEM_ready are both 1; DMEM_valid
// is a one-cycle strobe that qualifies DMEM_error and DMEM_data_out, which are 0 at all other times.
interface data_mem_ctrl_if;
  logic        DMEM_req;
  logic        DMEM_write;
  logic [1:0]  DMEM_size;
  logic        DMEM_unsigned;
  logic [31:0] DMEM_address;
  logic [31:0] DMEM_data_in;
  logic        DMEM_ready;
  logic        DMEM_valid;
  logic        DMEM_error;
  logic [31:0] DMEM_data_out;

  modport master (
    output DMEM_req, DMEM_write, DMEM_size, DMEM_unsigned, DMEM_address, DMEM_data_in,
    input  DMEM_ready, DMEM_valid, DMEM_error, DMEM_data_out
  );

  modport slave (
    input  DMEM_req, DMEM_write, DMEM_size, DMEM_unsigned, DMEM_address, DMEM_data_in,
    output DMEM_ready, DMEM_valid, DMEM_error, DMEM_data_out
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Word-organised data memory with byte/half/word access, fixed wait states and a
// power-up clear sweep that zeroes every word before the first request is accepted.
module data_mem_ctrl #(
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  data_mem_ctrl_if.slave   bus,
  output logic [1:0]       state_dbg
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [IW-1:0] clr_idx;
  logic [2:0]  wait_cnt;
  logic [31:0] a_addr, a_data;
  logic [1:0]  a_size;
  logic        a_write, a_uns;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] mem [DEPTH];

  logic        clr_last, access_now, fault, do_store;
  logic [29:0] widx;
  logic [31:0] rd_word, load_val, merged, wd;
  logic [3:0]  be;
  logic [7:0]  lane_byte;
  logic [15:0] half_word;

  assign clr_last   = (clr_idx == IW'(DEPTH - 1));
  assign access_now = (state == S_WAIT) && (wait_cnt == 3'(WAIT_CYCLES));
  assign widx       = a_addr[31:2];
  assign rd_word    = mem[widx[IW-1:0]];

  // Decode of the latched request; everything below depends only on captured values.
  assign fault = (a_size == 2'b11) ||
                 ((a_size == 2'b01) && a_addr[0]) ||
                 ((a_size == 2'b10) && (a_addr[1:0] != 2'b00)) ||
                 (widx >= 30'(DEPTH));
  assign do_store = access_now && a_write && !fault;

  always_comb begin
    case (a_addr[1:0])
      2'b00:   lane_byte = rd_word[7:0];
      2'b01:   lane_byte = rd_word[15:8];
      2'b10:   lane_byte = rd_word[23:16];
      default: lane_byte = rd_word[31:24];
    endcase
    half_word = a_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (a_size)
      2'b00:   load_val = a_uns ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      2'b01:   load_val = a_uns ? {16'h0, half_word} : {{16{half_word[15]}}, half_word};
      default: load_val = rd_word;
    endcase
  end

  always_comb begin
    case (a_size)
      2'b00: begin
        be = 4'b0001 << a_addr[1:0];
        wd = {4{a_data[7:0]}};
      end
      2'b01: begin
        be = a_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{a_data[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = a_data;
      end
    endcase
    merged = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wd[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_CLEAR) mem[clr_idx] <= '0;
    else if (do_store)    mem[widx[IW-1:0]] <= merged;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (clr_last) state_nxt = S_IDLE;
      S_IDLE:  if (bus.DMEM_req) state_nxt = S_WAIT;
      S_WAIT:  if (access_now) state_nxt = S_RESP;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_idx   <= '0;
      wait_cnt  <= '0;
      a_addr    <= '0;
      a_data    <= '0;
      a_size    <= '0;
      a_write   <= 1'b0;
      a_uns     <= 1'b0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: clr_idx <= clr_last ? '0 : clr_idx + 1'b1;
        S_IDLE: begin
          if (bus.DMEM_req) begin
            a_addr   <= bus.DMEM_address;
            a_data   <= bus.DMEM_data_in;
            a_size   <= bus.DMEM_size;
            a_write  <= bus.DMEM_write;
            a_uns    <= bus.DMEM_unsigned;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 3'd1;
          if (access_now) begin
            resp_err  <= fault;
            resp_data <= (fault || a_write) ? 32'h0 : load_val;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.DMEM_ready    = (state == S_IDLE);
    bus.DMEM_valid    = (state == S_RESP);
    bus.DMEM_error    = (state == S_RESP) && resp_err;
    bus.DMEM_data_out = (state == S_RESP) ? resp_data : 32'h0;
    state_dbg         = state;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed and randomized checks of data_mem_ctrl against a byte-array reference model.
module tb_data_mem_ctrl;
  localparam int DEPTH       = 16;
  localparam int WAIT_CYCLES = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;

  data_mem_ctrl_if bus ();

  data_mem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          valid_seen = 0;
  logic [7:0]  ref_mem [DEPTH*4];
  logic [32:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.DMEM_valid === 1'b1) valid_seen++;
    if (bus.DMEM_valid === 1'b0) begin
      chk("idle_data", bus.DMEM_data_out, 32'h0);
      chk("idle_err", 32'(bus.DMEM_error), 32'h0);
    end
  end

  // Reference: memory as a flat byte array, little-endian, accessed by byte address.
  function automatic void model_op(input logic w, input logic [1:0] sz, input logic u,
                                   input logic [31:0] a, input logic [31:0] d,
                                   output logic [31:0] ed, output logic ee);
    int nbytes;
    int base;
    logic [31:0] v;
    ed = 32'h0;
    ee = 1'b0;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (sz == 2'd3 || (a % nbytes) != 0 || (a / 4) >= DEPTH) begin
      ee = 1'b1;
      return;
    end
    base = int'(a);
    if (w) begin
      for (int i = 0; i < nbytes; i++) ref_mem[base+i] = d[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < nbytes; i++) v[8*i +: 8] = ref_mem[base+i];
      if (!u && nbytes < 4 && v[8*nbytes-1])
        for (int i = nbytes; i < 4; i++) v[8*i +: 8] = 8'hFF;
      ed = v;
    end
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic wait_ready(input string tag);
    int guard;
    guard = 0;
    @(negedge clk);
    while (bus.DMEM_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_ready"}, 32'(bus.DMEM_ready), 32'h1);
  endtask

  task automatic scramble();
    bus.DMEM_req      = 1'b0;
    bus.DMEM_write    = 1'($urandom_range(0, 1));
    bus.DMEM_size     = 2'($urandom_range(0, 3));
    bus.DMEM_unsigned = 1'($urandom_range(0, 1));
    bus.DMEM_address  = $urandom;
    bus.DMEM_data_in  = $urandom;
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    bus.DMEM_req      = 1'b1;
    bus.DMEM_write    = w;
    bus.DMEM_size     = sz;
    bus.DMEM_unsigned = u;
    bus.DMEM_address  = a;
    bus.DMEM_data_in  = d;
  endtask

  task automatic txn(input string tag, input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] got_d, output logic got_e);
    logic [31:0] ed;
    logic        ee;
    logic [32:0] exp;
    int          lat;
    model_op(w, sz, u, a, d, ed, ee);
    exp_q.push_back({ee, ed});
    wait_ready(tag);
    drive(w, sz, u, a, d);
    @(posedge clk);
    #1 scramble();
    lat = 0;
    while (bus.DMEM_valid !== 1'b1 && lat < 50) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(WAIT_CYCLES + 1));
    got_d = bus.DMEM_data_out;
    got_e = bus.DMEM_error;
    exp = exp_q.pop_front();
    chk({tag, "_data"}, got_d, exp[31:0]);
    chk({tag, "_err"}, 32'(got_e), 32'(exp[32]));
    @(posedge clk);
    #1 chk({tag, "_valid_len"}, 32'(bus.DMEM_valid), 32'h0);
  endtask

  task automatic count_clear(input string tag);
    int cnt;
    cnt = 0;
    while (bus.DMEM_ready !== 1'b1 && cnt < 100) begin
      @(posedge clk);
      #1 cnt++;
    end
    chk(tag, 32'(cnt), 32'(DEPTH));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] gd;
    logic        ge;
    logic [31:0] ed;
    logic        ee;
    logic [32:0] exp;
    int          v0;
    int          first_ready;
    int          lat;

    reset = 1'b0;
    bus.DMEM_req = 1'b0;
    bus.DMEM_write = 1'b0;
    bus.DMEM_size = 2'b10;
    bus.DMEM_unsigned = 1'b0;
    bus.DMEM_address = 32'h0;
    bus.DMEM_data_in = 32'h0;
    clear_model();

    // Reset and clear sweep
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.DMEM_ready), 32'h0);
    chk("rst_valid", 32'(bus.DMEM_valid), 32'h0);
    chk("rst_error", 32'(bus.DMEM_error), 32'h0);
    chk("rst_data", bus.DMEM_data_out, 32'h0);
    reset = 1'b0;
    count_clear("clear_cycles");

    txn("ld3c", 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, gd, ge);
    chk("ld3c_lit", gd, 32'h0);

    // Word store/load and sub-word access
    txn("st08", 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, gd, ge);
    chk("st08_lit", gd, 32'h0);
    txn("ld08", 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, gd, ge);
    chk("ld08_lit", gd, 32'hDEADBEEF);
    txn("stb09", 1'b1, 2'b00, 1'b0, 32'h09, 32'hFFFFFF11, gd, ge);
    txn("ld08b", 1'b0, 2'b10, 1'b1, 32'h08, 32'h0, gd, ge);
    chk("ld08b_lit", gd, 32'hDEAD11EF);
    txn("lbs0b", 1'b0, 2'b00, 1'b0, 32'h0B, 32'h0, gd, ge);
    chk("lbs0b_lit", gd, 32'hFFFFFFDE);
    txn("lbu0b", 1'b0, 2'b00, 1'b1, 32'h0B, 32'h0, gd, ge);
    chk("lbu0b_lit", gd, 32'h000000DE);
    txn("lhs0a", 1'b0, 2'b01, 1'b0, 32'h0A, 32'h0, gd, ge);
    chk("lhs0a_lit", gd, 32'hFFFFDEAD);
    txn("lhu0a", 1'b0, 2'b01, 1'b1, 32'h0A, 32'h0, gd, ge);
    chk("lhu0a_lit", gd, 32'h0000DEAD);

    // Faults
    txn("stw0a", 1'b1, 2'b10, 1'b0, 32'h0A, 32'hCAFEF00D, gd, ge);
    chk("stw0a_lit_err", 32'(ge), 32'h1);
    chk("stw0a_lit_data", gd, 32'h0);
    txn("ld08c", 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, gd, ge);
    chk("ld08c_lit", gd, 32'hDEAD11EF);
    txn("ld40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, gd, ge);
    chk("ld40_lit_err", 32'(ge), 32'h1);
    txn("sz11", 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, gd, ge);
    chk("sz11_lit_err", 32'(ge), 32'h1);
    txn("sth09", 1'b1, 2'b01, 1'b0, 32'h09, 32'h1234, gd, ge);
    chk("sth09_lit_err", 32'(ge), 32'h1);
    txn("big", 1'b1, 2'b00, 1'b0, 32'h8000_0000, 32'h55, gd, ge);
    chk("big_lit_err", 32'(ge), 32'h1);

    // Request held high while busy: one response, re-acceptance only from IDLE
    model_op(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, ed, ee);
    exp_q.push_back({ee, ed});
    exp_q.push_back({ee, ed});
    wait_ready("busy");
    v0 = valid_seen;
    first_ready = 0;
    drive(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    @(posedge clk);
    for (int t = 1; t <= WAIT_CYCLES + 2; t++) begin
      @(posedge clk);
      #1;
      if (bus.DMEM_valid === 1'b1) begin
        exp = exp_q.pop_front();
        chk("busy1_data", bus.DMEM_data_out, exp[31:0]);
      end
      if (bus.DMEM_ready === 1'b1 && first_ready == 0) first_ready = t;
    end
    @(negedge clk);
    chk("busy_resp_count", 32'(valid_seen - v0), 32'h1);
    chk("busy_first_ready", 32'(first_ready), 32'(WAIT_CYCLES + 2));
    @(posedge clk);
    #1 bus.DMEM_req = 1'b0;
    chk("busy_reaccept", 32'(bus.DMEM_ready), 32'h0);
    lat = 0;
    while (bus.DMEM_valid !== 1'b1 && lat < 50) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("busy2_latency", 32'(lat), 32'(WAIT_CYCLES + 1));
    exp = exp_q.pop_front();
    chk("busy2_data", bus.DMEM_data_out, exp[31:0]);
    repeat (10) @(posedge clk);
    chk("busy_total", 32'(valid_seen - v0), 32'h2);

    // Randomized traffic, some of it out of range or misaligned
    for (int n = 0; n < 150; n++) begin
      txn("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          32'($urandom_range(0, DEPTH*4 + 7)), $urandom, gd, ge);
    end

    // Reset in the middle of a store's wait states
    txn("st04a", 1'b1, 2'b10, 1'b0, 32'h04, 32'h0BADCAFE, gd, ge);
    wait_ready("rstw");
    v0 = valid_seen;
    drive(1'b1, 2'b10, 1'b0, 32'h04, 32'h12345678);
    @(posedge clk);
    #1 scramble();
    @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("rstw_ready", 32'(bus.DMEM_ready), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_model();
    count_clear("rstw_clear_cycles");
    chk("rstw_no_valid", 32'(valid_seen - v0), 32'h0);
    txn("ld04", 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, gd, ge);
    chk("ld04_lit", gd, 32'h0);
    txn("ld08z", 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, gd, ge);
    chk("ld08z_lit", gd, 32'h0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
